// File: rtl/ulaplus_palette_ctrl.sv
// ---------------------------------------------------------------------------
// ulaplus_palette_ctrl
//
// CPU-side front end and access arbiter for the 64-byte ULAplus palette RAM
// (asynchronous read, synchronous write). It decodes the two ULAplus I/O
// ports from the Z80 bus and holds the register-select and mode registers.
// It shares the single RAM address port between video lookups and CPU
// accesses. Video always wins, and the CPU is stalled through wait_n when its
// access cannot complete.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   cpu_a, cpu_din           Z80 address bus / write data (synchronous to clk)
//   iorq_n, rd_n, wr_n       Z80 I/O strobes, active low
//   cpu_dout, cpu_oe         data-port read data and its bus-drive enable
//   wait_n                   Z80 WAIT, active low
//   vid_req, vid_idx         video palette lookup request and index
//   vid_color, vid_valid     registered palette entry (GGGRRRBB), update flag
//   ulap_en                  mode register bit 0
//   ram_a, ram_din, ram_we   palette RAM address / write data / write enable
//   ram_dout                 palette RAM read data (combinational)
//
// Handshake: a CPU access is taken on the clock edge where the FSM is IDLE,
// a port-matched strobe is high and served is clear. served then stays set
// until both strobes are seen low, so a single long bus cycle is taken only
// once. While an access cannot be taken or finished, wait_n is held low.
// ---------------------------------------------------------------------------
module ulaplus_palette_ctrl #(
  parameter logic [15:0] SELPORT  = 16'hBF3B,
  parameter logic [15:0] DATAPORT = 16'hFF3B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_din,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe,
  output logic        wait_n,
  input  logic        vid_req,
  input  logic [5:0]  vid_idx,
  output logic [7:0]  vid_color,
  output logic        vid_valid,
  output logic        ulap_en,
  output logic [5:0]  ram_a,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WPEND = 2'd1,
    RPEND = 2'd2,
    RDONE = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  sel;
  logic        mode;
  logic [13:0] wbuf;   // {palette index, data} of the write waiting for the RAM
  logic [7:0]  rdbuf;
  logic        served;

  logic wstb;
  logic rstb;
  logic sel_hit;
  logic data_hit;
  logic wr_sel;
  logic wr_data;
  logic rd_data;
  logic acc_any;
  logic accept;

  assign wstb     = ~iorq_n & ~wr_n;
  assign rstb     = ~iorq_n & ~rd_n;
  assign sel_hit  = (cpu_a == SELPORT);
  assign data_hit = (cpu_a == DATAPORT);

  // The select port is write-only, so only the data port answers reads.
  assign wr_sel  = wstb & sel_hit;
  assign wr_data = wstb & data_hit;
  assign rd_data = rstb & data_hit;
  assign acc_any = wr_sel | wr_data | rd_data;
  assign accept  = (state == IDLE) & acc_any & ~served;

  // A fresh access arriving while the FSM is busy is held off until it can
  // be taken from IDLE; a palette read is held until the RAM is free.
  assign wait_n = ~((state == RPEND) | ((state != IDLE) & acc_any & ~served));

  assign cpu_oe   = (state == RDONE) & rstb;
  assign cpu_dout = rdbuf;
  assign ulap_en  = mode;

  // Video owns the RAM port whenever it asks; CPU writes only fire on free
  // cycles, so ram_we can never collide with a video lookup.
  always_comb begin
    ram_a = sel[5:0];
    if (vid_req) begin
      ram_a = vid_idx;
    end else if (state == WPEND) begin
      ram_a = wbuf[13:8];
    end
  end

  assign ram_din = wbuf[7:0];
  assign ram_we  = (state == WPEND) & ~vid_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 8'h00;
      mode      <= 1'b0;
      wbuf      <= 14'h0000;
      rdbuf     <= 8'h00;
      served    <= 1'b0;
      vid_color <= 8'h00;
      vid_valid <= 1'b0;
    end else begin
      if (accept) begin
        served <= 1'b1;
      end else if (~wstb & ~rstb) begin
        served <= 1'b0;
      end

      // Video lookup has a fixed latency of one cycle.
      if (vid_req) begin
        vid_color <= ram_dout;
        vid_valid <= 1'b1;
      end else begin
        vid_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (wr_sel) begin
              sel <= cpu_din;
            end else if (wr_data) begin
              case (sel[7:6])
                2'b00: begin
                  wbuf  <= {sel[5:0], cpu_din};
                  state <= WPEND;
                end
                2'b01:   mode <= cpu_din[0];
                default: ;  // unknown group: write is swallowed
              endcase
            end else begin
              case (sel[7:6])
                2'b00: state <= RPEND;
                2'b01: begin
                  rdbuf <= {7'b0000000, mode};
                  state <= RDONE;
                end
                default: begin
                  rdbuf <= 8'hFF;
                  state <= RDONE;
                end
              endcase
            end
          end
        end
        WPEND: begin
          if (~vid_req) begin
            state <= IDLE;
          end
        end
        RPEND: begin
          if (~vid_req) begin
            rdbuf <= ram_dout;
            state <= RDONE;
          end
        end
        RDONE: begin
          // Hold the read data on the bus until the CPU drops RD.
          if (~rstb) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulaplus_palette_ctrl.sv
module tb_ulaplus_palette_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_din = 8'h00;
  logic        iorq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [7:0]  cpu_dout;
  logic        cpu_oe;
  logic        wait_n;
  logic        vid_req = 1'b0;
  logic [5:0]  vid_idx = 6'd0;
  logic [7:0]  vid_color;
  logic        vid_valid;
  logic        ulap_en;
  logic [5:0]  ram_a;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  always #5 clk = ~clk;

  ulaplus_palette_ctrl dut (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_din(cpu_din),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .cpu_dout(cpu_dout), .cpu_oe(cpu_oe), .wait_n(wait_n),
    .vid_req(vid_req), .vid_idx(vid_idx), .vid_color(vid_color), .vid_valid(vid_valid),
    .ulap_en(ulap_en), .ram_a(ram_a), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // palette RAM: async read, sync write
  logic [7:0] ram_mem [64];
  assign ram_dout = ram_mem[ram_a];

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // reference model of the CPU-visible register file and palette contents
  logic [7:0] m_sel;
  logic       m_mode;
  logic [7:0] m_pal [64];

  // video driver controls
  int cyc = 0;
  int force_until = 0;
  int sw_start = 0;
  int vid_mode = 0;     // 0 idle, 1 random, 2 index sweep
  logic pal_chk = 1'b0;

  // monitor state
  logic [7:0] exp_q[$];
  logic [7:0] pal_q[$];
  int   we_cnt = 0;
  logic [5:0] last_we_a;
  logic [7:0] last_we_d;

  typedef struct {
    logic        is_rd;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_d;
    logic        exp_oe;
    logic        nowait;
    logic        exp_ulap;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic is_rd, input logic [15:0] a, input logic [7:0] d,
                              input logic [7:0] exp_d, input logic exp_oe, input logic nowait,
                              input logic exp_ulap);
    vec_t v;
    v.is_rd = is_rd; v.a = a; v.d = d; v.exp_d = exp_d;
    v.exp_oe = exp_oe; v.nowait = nowait; v.exp_ulap = exp_ulap;
    return v;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_out(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'hBF3B) m_sel = d;
    else if (a == 16'hFF3B) begin
      if (m_sel[7:6] == 2'b00) m_pal[m_sel[5:0]] = d;
      else if (m_sel[7:6] == 2'b01) m_mode = d[0];
    end
  endtask

  function automatic logic [7:0] model_in();
    if (m_sel[7:6] == 2'b00) return m_pal[m_sel[5:0]];
    if (m_sel[7:6] == 2'b01) return {7'b0000000, m_mode};
    return 8'hFF;
  endfunction

  // ---------------- background processes ----------------
  task automatic ram_proc();
    forever begin
      @(posedge clk);
      if (ram_we) ram_mem[ram_a] <= ram_din;
    end
  endtask

  task automatic vid_driver();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < force_until) begin
        vid_req = 1'b1;
        vid_idx = 6'($urandom_range(0, 63));
      end else if (vid_mode == 2 && cyc >= sw_start && cyc < sw_start + 64) begin
        vid_req = 1'b1;
        vid_idx = 6'(cyc - sw_start);
      end else if (vid_mode == 1) begin
        vid_req = ($urandom_range(0, 2) == 0);
        vid_idx = 6'($urandom_range(0, 63));
      end else begin
        vid_req = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic prev_req;
    logic prev_pal;
    logic [7:0] e;
    prev_req = 1'b0;
    prev_pal = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pal_q.delete();
        prev_req = 1'b0;
        prev_pal = 1'b0;
      end else begin
        chk("vid_valid", vid_valid, prev_req);
        if (prev_req && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("vid_color", vid_color, e);
        end
        if (prev_pal && pal_q.size() > 0) begin
          e = pal_q.pop_front();
          chk("vid_sweep", vid_color, e);
        end
        if (ram_we) begin
          we_cnt++;
          last_we_a = ram_a;
          last_we_d = ram_din;
          chk("we_vs_vid", vid_req, 0);
        end
        prev_req = vid_req;
        prev_pal = vid_req & pal_chk;
        if (vid_req) exp_q.push_back(ram_mem[vid_idx]);
        if (prev_pal) pal_q.push_back(m_pal[vid_idx]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One Z80 I/O cycle: strobe held until WAIT has been seen high twice,
  // data captured on the second, then one idle cycle.
  task automatic io_op(input logic is_rd, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] dout, output logic oe, output int wlow);
    int hi;
    int n;
    @(posedge clk);
    #1;
    cpu_a = a; cpu_din = d; iorq_n = 1'b0;
    if (is_rd) rd_n = 1'b0; else wr_n = 1'b0;
    hi = 0; n = 0; wlow = 0; dout = 8'h00; oe = 1'b0;
    while (hi < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (wait_n) begin
        hi++;
        if (hi == 2) begin
          dout = cpu_dout;
          oe = cpu_oe;
        end
      end else begin
        wlow++;
      end
      if (hi < 2) @(posedge clk);
    end
    if (hi < 2) chk("io_timeout", n, 0);
    @(posedge clk);
    #1;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; cpu_a = 16'h0000;
  endtask

  task automatic do_op(input logic is_rd, input logic [15:0] a, input logic [7:0] d,
                       input logic upd, output logic [7:0] dout, output logic oe, output int wlow);
    if (upd && !is_rd) model_out(a, d);
    io_op(is_rd, a, d, dout, oe, wlow);
  endtask

  task automatic set_force(input int n);
    @(negedge clk);
    #1;
    force_until = cyc + n + 1;
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [7:0] dout;
    logic oe;
    int wlow;
    int base;
    logic [7:0] e;
    int r;

    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 8'(i * 37 + 11);
      m_pal[i]   = 8'(i * 37 + 11);
    end
    m_sel = 8'h00;
    m_mode = 1'b0;

    fork
      ram_proc();
      vid_driver();
      monitor();
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_wait_n", wait_n, 1);
    chk("rst_cpu_oe", cpu_oe, 0);
    chk("rst_ulap_en", ulap_en, 0);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_vid_color", vid_color, 0);
    chk("rst_ram_we", ram_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // table-driven register / palette accesses, video idle
    vecs.push_back(mk(0, 16'hBF3B, 8'h40, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 16'hFF3B, 8'h01, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 16'hFF3B, 8'h00, 8'h01, 1, 1, 1));
    vecs.push_back(mk(0, 16'hBF3B, 8'h80, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 16'hFF3B, 8'h00, 8'hFF, 1, 1, 1));
    vecs.push_back(mk(0, 16'hFF3B, 8'h00, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 16'hBF3B, 8'hC0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 16'hFF3B, 8'h00, 8'hFF, 1, 1, 1));
    vecs.push_back(mk(0, 16'hBF3B, 8'h40, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 16'hFF3B, 8'h00, 8'h01, 1, 1, 1));
    vecs.push_back(mk(0, 16'h7F3B, 8'h00, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 16'hBF3B, 8'h0A, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 16'hFF3B, 8'h3C, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 16'hFF3B, 8'h00, 8'h3C, 1, 0, 1));
    vecs.push_back(mk(0, 16'hBF3B, 8'h3F, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 16'hFF3B, 8'hA5, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 16'hFF3B, 8'h00, 8'hA5, 1, 0, 1));
    vecs.push_back(mk(0, 16'hBF3B, 8'h4A, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 16'hFF3B, 8'hFE, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 16'hFF3B, 8'h00, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 16'hBF3B, 8'h0A, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 16'hFF3B, 8'h77, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 16'hFF3B, 8'h00, 8'h77, 1, 0, 0));
    vecs.push_back(mk(1, 16'h00FE, 8'h00, 8'h00, 0, 1, 0));

    foreach (vecs[i]) begin
      do_op(vecs[i].is_rd, vecs[i].a, vecs[i].d, 1'b1, dout, oe, wlow);
      if (vecs[i].is_rd) begin
        chk("tbl_oe", oe, vecs[i].exp_oe);
        if (vecs[i].exp_oe) chk("tbl_dout", dout, vecs[i].exp_d);
        if (vecs[i].nowait) chk("tbl_nowait", wlow, 0);
      end
      chk("tbl_ulap", ulap_en, vecs[i].exp_ulap);
    end

    // single palette write with the RAM free
    do_op(0, 16'hBF3B, 8'h05, 1'b1, dout, oe, wlow);
    base = we_cnt;
    do_op(0, 16'hFF3B, 8'hE3, 1'b1, dout, oe, wlow);
    repeat (3) @(negedge clk);
    chk("wr_we_count", we_cnt - base, 1);
    chk("wr_ram_a", last_we_a, 6'd5);
    chk("wr_ram_din", last_we_d, 8'hE3);

    // same write while video holds the RAM for 20 cycles
    do_op(0, 16'hBF3B, 8'h05, 1'b1, dout, oe, wlow);
    base = we_cnt;
    set_force(20);
    do_op(0, 16'hFF3B, 8'hE3, 1'b1, dout, oe, wlow);
    chk("stall_no_we", we_cnt - base, 0);
    repeat (25) @(negedge clk);
    chk("stall_we_count", we_cnt - base, 1);
    chk("stall_ram_a", last_we_a, 6'd5);
    chk("stall_ram_din", last_we_d, 8'hE3);

    // palette read stalled by video for 3 cycles
    set_force(3);
    do_op(1, 16'hFF3B, 8'h00, 1'b1, dout, oe, wlow);
    chk("rd_stall_wait", (wlow >= 3), 1);
    chk("rd_stall_dout", dout, 8'hE3);
    chk("rd_stall_oe", oe, 1);

    // mode read without wait
    do_op(0, 16'hBF3B, 8'h40, 1'b1, dout, oe, wlow);
    do_op(0, 16'hFF3B, 8'h01, 1'b1, dout, oe, wlow);
    chk("mode_ulap", ulap_en, 1);
    do_op(1, 16'hFF3B, 8'h00, 1'b1, dout, oe, wlow);
    chk("mode_dout", dout, 8'h01);
    chk("mode_nowait", wlow, 0);

    // reset while a palette write is stuck behind video
    do_op(0, 16'hBF3B, 8'h07, 1'b1, dout, oe, wlow);
    set_force(60);
    io_op(0, 16'hFF3B, 8'h99, dout, oe, wlow);
    base = we_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_wait_n", wait_n, 1);
    chk("rst2_ulap_en", ulap_en, 0);
    chk("rst2_vid_color", vid_color, 0);
    chk("rst2_vid_valid", vid_valid, 0);
    chk("rst2_ram_we", ram_we, 0);
    @(negedge clk);
    #1;
    force_until = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_sel = 8'h00;
    m_mode = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst2_no_we", we_cnt - base, 0);
    chk("rst2_pal7", ram_mem[7], m_pal[7]);
    chk("rst2_ulap_after", ulap_en, 0);

    // video sweep over the whole palette
    @(negedge clk);
    #1;
    pal_chk = 1'b1;
    sw_start = cyc + 1;
    vid_mode = 2;
    repeat (67) @(posedge clk);
    @(negedge clk);
    #1;
    vid_mode = 0;
    pal_chk = 1'b0;

    // randomized traffic with random video contention
    vid_mode = 1;
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        if ($urandom_range(0, 4) == 0) e = 8'($urandom_range(0, 255));
        else e = {2'b00, 6'($urandom_range(0, 63))};
        do_op(0, 16'hBF3B, e, 1'b1, dout, oe, wlow);
      end else if (r <= 5) begin
        do_op(0, 16'hFF3B, 8'($urandom_range(0, 255)), 1'b1, dout, oe, wlow);
      end else if (r <= 8) begin
        e = model_in();
        do_op(1, 16'hFF3B, 8'h00, 1'b1, dout, oe, wlow);
        chk("rnd_dout", dout, e);
        chk("rnd_oe", oe, 1);
      end else begin
        do_op(1, 16'h3F3B, 8'h00, 1'b1, dout, oe, wlow);
        chk("rnd_foreign_oe", oe, 0);
        do_op(0, 16'hBF3A, 8'($urandom_range(0, 255)), 1'b1, dout, oe, wlow);
      end
      chk("rnd_ulap", ulap_en, m_mode);
    end

    // drain and compare palette contents
    @(negedge clk);
    #1;
    vid_mode = 0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_pal", ram_mem[i], m_pal[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
